cipher_word_drain: RTL and testbench

//  Downstream drain for the SPECK-hash/RC4 encryption datapath. After the RC4 result store is complete,
//  it sweeps add_to_read over every word and captures final_out into a small FIFO.
//  It presents the captured words to the RISC-V core as a valid/ready stream, with last asserted on the final beat.
//  It is the only reader of the RC4 result store once encryption is complete.

---
 rtl/cipher_drain_pkg.sv | 24 ++
 rtl/cipher_word_drain_fifo.sv | 67 ++++++
 rtl/cipher_word_drain.sv | 171 +++++++++++++++++
 tb/tb_cipher_word_drain.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_drain_pkg.sv
// cipher_drain_pkg: shared FSM encoding, default sizes and FIFO count width
// for the cipher_word_drain block.
package cipher_drain_pkg;

  localparam int DEF_DW         = 32;
  localparam int DEF_AW         = 4;
  localparam int DEF_WORDS      = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // A FIFO occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } drain_state_t;

endpackage

// File: rtl/cipher_word_drain_fifo.sv
// drain_fifo: small synchronous FIFO holding drained words ahead of the
// output stream. The head entry comes straight from storage flops, so it is
// stable for as long as it is not popped. Push and pop together are accepted
// when full. DEPTH must be a power of two so the pointers wrap naturally.
module drain_fifo
  import cipher_drain_pkg::*;
#(
  parameter int W     = DEF_DW + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; written at the tail on every accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the storage is reset on purpose: the head drives the output
      // data port directly, which must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_word_drain.sv
// cipher_word_drain: reads every word of the RC4 result store once encryption
// is complete and streams it to the core over valid/ready, with m_last on the
// final beat. At most one store read is in flight; issue is throttled so the
// FIFO can never overflow while the core stalls.
// Optional feature macro: DRAIN_CHECKSUM_EN appends an XOR checksum beat that
// carries m_last instead of the final data word.
module cipher_word_drain
  import cipher_drain_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int WORDS      = DEF_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] final_out,
  output logic [AW-1:0] add_to_read,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  localparam int            CW        = cnt_width(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [CW:0]   DEPTH_V   = (CW + 1)'(FIFO_DEPTH);

  drain_state_t  state;
  drain_state_t  next_state;
  logic [AW-1:0] rd_addr;
  logic          inflight;
  logic          issue;
  logic          last_issue;
  logic          pop;
  logic          push;
  logic          room;
  logic [DW:0]   push_entry;
  logic [DW:0]   head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW:0]   occupancy;

  // rd_addr is 0 whenever the FSM is idle, so the store already presents
  // word 0 and the start cycle itself counts as the first issue.
  assign add_to_read = rd_addr;
  assign pop         = m_valid && m_ready;
  assign m_valid     = !fifo_empty;
  assign m_data      = head[DW-1:0];
  assign m_last      = m_valid && head[DW];
  assign busy        = (state == ISSUE) || (state == DRAIN);
  assign done        = (state == FIN);

  // Words buffered plus the read still on its way must leave a free slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign room      = !fifo_full && (occupancy < DEPTH_V);

  // Next-state and issue decision.
  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned (latch).
    next_state = state;
    issue      = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          issue      = 1'b1;
          last_issue = (rd_addr == LAST_ADDR);
          next_state = last_issue ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (room) begin
          issue      = 1'b1;
          last_issue = (rd_addr == LAST_ADDR);
          if (last_issue) next_state = DRAIN;
        end
      end
      DRAIN:   if (pop && m_last) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Read address walk (stops at the last word) and in-flight flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == FIN)              rd_addr <= '0;
      else if (issue && !last_issue) rd_addr <= rd_addr + 1'b1;
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [DW-1:0] csum;
  logic          csum_done;
  logic          csum_push;

  // Checksum beat goes in once the last data word has landed in the FIFO.
  assign csum_push = (state == DRAIN) && !inflight && !csum_done &&
                     (!fifo_full || pop);

  // Running XOR of drained words; cleared when a new drain starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum      <= '0;
      csum_done <= 1'b0;
    end else if ((state == IDLE) && start) begin
      csum      <= '0;
      csum_done <= 1'b0;
    end else begin
      if (inflight)  csum      <= csum ^ final_out;
      if (csum_push) csum_done <= 1'b1;
    end
  end

  // FIFO write: store data while a read returns, then the checksum beat.
  always_comb begin
    push       = inflight;
    push_entry = {1'b0, final_out};
    if (csum_push) begin
      push       = 1'b1;
      push_entry = {1'b1, csum};
    end
  end
`else
  logic inflight_last;

  // Remembers whether the returning read carries the final address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight_last <= 1'b0;
    else        inflight_last <= issue && last_issue;
  end

  // FIFO write: store data while a read returns, tagged with its last flag.
  always_comb begin
    push       = inflight;
    push_entry = {inflight_last, final_out};
  end
`endif

  drain_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_cipher_word_drain.sv
// tb_cipher_word_drain: table-driven drain scenarios plus hand-written reset
// and checksum sequences for cipher_word_drain.
module tb_cipher_word_drain;

  localparam int WORDS = 16;
`ifdef DRAIN_CHECKSUM_EN
  localparam int EXP_BEATS = WORDS + 1;
`else
  localparam int EXP_BEATS = WORDS;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] final_out;
  logic [3:0]  add_to_read;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  cipher_word_drain #(
    .DW(32), .AW(4), .WORDS(WORDS), .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .final_out   (final_out),
    .add_to_read (add_to_read),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result store: synchronous read, data one cycle after the address.
  logic [31:0] store [WORDS];
  always @(posedge clk) final_out <= store[add_to_read];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: records accepted beats, done pulses, latency and holds.
  int          cycle_no = 0;
  logic [32:0] beat_q[$];
  int          done_cnt = 0;
  int          stab_viol = 0;
  int          lat = -1;
  int          start_cyc = 0;
  int          last_acc_cyc = 0;
  int          done_cyc = 0;
  bit          armed = 1'b0;
  bit          prev_hold = 1'b0;
  logic [32:0] prev_beat = '0;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
      armed     = 1'b0;
    end else begin
      if (prev_hold && (!m_valid || {m_last, m_data} !== prev_beat)) stab_viol++;
      if (start && !busy) begin
        armed = 1'b1; start_cyc = cycle_no; lat = -1;
      end
      if (armed && m_valid) begin
        lat = cycle_no - start_cyc; armed = 1'b0;
      end
      if (m_valid && m_ready) begin
        beat_q.push_back({m_last, m_data});
        if (m_last) last_acc_cyc = cycle_no;
      end
      if (done) begin
        done_cnt++; done_cyc = cycle_no;
      end
      prev_hold = m_valid && !m_ready;
      prev_beat = {m_last, m_data};
    end
  end

  typedef struct {
    string name;
    int    mode;        // 0: ready high, 1: ready low for 'low' cycles, 2: toggle
    int    low;
    int    restart_at;  // cycle of a second start pulse, -1 for none
    int    exp_stall;   // add_to_read while stalled, -1 to skip
    int    exp_beats;
    int    exp_done;
    int    exp_lat;
  } vec_t;

  vec_t vecs [4];

  function automatic logic ready_at(input int mode, input int low, input int cyc);
    case (mode)
      1:       return (cyc >= low);
      2:       return cyc[0];
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_vec(input int v, output int base);
    int          d0, s0, cyc, stall, n;
    bit          finished;
    logic [31:0] xsum;
    logic [32:0] exp;
    base = beat_q.size();
    d0 = done_cnt;
    s0 = stab_viol;
    stall = -1;
    finished = 1'b0;
    cyc = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    m_ready = ready_at(vecs[v].mode, vecs[v].low, 0);
    while (!finished && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start   = (cyc == vecs[v].restart_at);
      m_ready = ready_at(vecs[v].mode, vecs[v].low, cyc);
      if (cyc == 18) stall = int'(add_to_read);
      if (done_cnt != d0) finished = 1'b1;
    end
    check({vecs[v].name, "_finished"}, finished, 1);
    start   = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n = beat_q.size() - base;
    check({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
    check({vecs[v].name, "_beats"}, n, vecs[v].exp_beats);
    check({vecs[v].name, "_dones"}, done_cnt - d0, vecs[v].exp_done);
    check({vecs[v].name, "_done_after_last"}, done_cyc - last_acc_cyc, 1);
    check({vecs[v].name, "_held_stable"}, stab_viol - s0, 0);
    check({vecs[v].name, "_busy_end"}, busy, 0);
    check({vecs[v].name, "_valid_end"}, m_valid, 0);
    check({vecs[v].name, "_addr_end"}, add_to_read, 0);
    if (vecs[v].exp_stall >= 0)
      check({vecs[v].name, "_stall_addr"}, stall, vecs[v].exp_stall);
    xsum = '0;
    for (int i = 0; i < WORDS; i++) xsum ^= store[i];
    for (int i = 0; i < n && i < EXP_BEATS; i++) begin
      if (i < WORDS) exp = {(i == EXP_BEATS - 1), store[i]};
      else           exp = {1'b1, xsum};
      check($sformatf("%s_beat%0d", vecs[v].name, i), beat_q[base + i], exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, d0, guard;

    vecs[0] = '{"in_order",        0, 0,  -1, -1, EXP_BEATS, 1, 2};
    vecs[1] = '{"backpressure",    1, 20, -1,  4, EXP_BEATS, 1, 2};
    vecs[2] = '{"toggle_ready",    2, 0,  -1, -1, EXP_BEATS, 1, 2};
    vecs[3] = '{"restart_ignored", 0, 0,   5, -1, EXP_BEATS, 1, 2};

    for (int i = 0; i < WORDS; i++) store[i] = 32'hA5A5_0000 + i;

    reset   = 1'b0;
    start   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_add_to_read", add_to_read, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 4; v++) run_vec(v, base);

    // Reset in the middle of a drain, after seven beats were accepted.
    base = beat_q.size();
    d0   = done_cnt;
    @(posedge clk); #1;
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while ((beat_q.size() - base) < 7 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_beats_before_reset", beat_q.size() - base, 7);
    check("abort_busy_before_reset", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_add_to_read", add_to_read, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_beats_total", beat_q.size() - base, 7);
    run_vec(0, base);
    check("restart_first_word", beat_q[base], {1'b0, 32'hA5A5_0000});

`ifdef DRAIN_CHECKSUM_EN
    store[0] = 32'h0000_00F0;
    for (int i = 1; i < WORDS; i++) store[i] = 32'h0000_0001;
    run_vec(0, base);
    check("csum_beat17", beat_q[base + WORDS], {1'b1, 32'h0000_00F1});
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
